// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer: one outstanding fetch over a
// req/gnt/rvalid handshake, held instruction for decode, sticky trap on misaligned targets.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] npc_i,
    input  logic        advance_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        misalign_o,
    output logic [31:0] fetch_cnt_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_VALID = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic        mis_q, mis_d;

    // Sequencer next state and datapath updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt_i) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid_i) begin
                    inst_d  = imem_rdata_i;
                    valid_d = 1'b1;
                    state_d = ST_VALID;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_VALID: begin
                if (advance_i) begin
                    cnt_d   = cnt_q + 32'd1;
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                    pc_d    = npc_i;
                    // A misaligned target is still latched so the trap handler sees it.
                    if (npc_i[1:0] == 2'b00) begin
                        state_d = ST_REQ;
                    end else begin
                        mis_d   = 1'b1;
                        state_d = ST_FAULT;
                    end
                end else begin
                    state_d = ST_VALID;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                inst_d  = NOP_INST;
            end
        endcase
        req_d = (state_d == ST_REQ);
    end

    // State and output registers; request flag tracks the REQ state exactly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            cnt_q   <= 32'd0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign misalign_o   = mis_q;
    assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by random
// memory timing, retire and branch traffic checked against a transaction model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rstn;
    logic [31:0] npc_i;
    logic        advance_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        misalign_o;
    logic [31:0] fetch_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model view of the fetch unit, at transaction level.
    logic [31:0] exp_pc, exp_inst, exp_cnt;
    logic        exp_req, exp_valid, exp_mis;
    logic        in_flight, idle_pending;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .npc_i         (npc_i),
        .advance_i     (advance_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .misalign_o    (misalign_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_0000) return 32'h0050_0093;
        else return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Entered and left on a falling edge; reset is asserted mid-cycle.
    task automatic do_reset();
        #2 rstn = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        advance_i     = 1'b0;
        #1;
        check_eq("rst_req",   {31'd0, imem_req_o},   32'd0);
        check_eq("rst_pc",    pc_o,                  RESET_PC);
        check_eq("rst_inst",  inst_o,                NOP_INST);
        check_eq("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("rst_mis",   {31'd0, misalign_o},   32'd0);
        check_eq("rst_cnt",   fetch_cnt_o,           32'd0);
        exp_pc = RESET_PC; exp_inst = NOP_INST; exp_cnt = 32'd0;
        exp_req = 1'b0; exp_valid = 1'b0; exp_mis = 1'b0;
        in_flight = 1'b0; idle_pending = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Check this cycle's outputs, drive inputs for the coming edge, advance the model.
    task automatic drive_cycle(input logic gnt, input logic rv, input logic adv, input logic [31:0] npc);
        check_eq("req",      {31'd0, imem_req_o},   {31'd0, exp_req});
        check_eq("addr",     imem_addr_o,           exp_pc);
        check_eq("pc",       pc_o,                  exp_pc);
        check_eq("inst",     inst_o,                exp_inst);
        check_eq("valid",    {31'd0, inst_valid_o}, {31'd0, exp_valid});
        check_eq("misalign", {31'd0, misalign_o},   {31'd0, exp_mis});
        check_eq("cnt",      fetch_cnt_o,           exp_cnt);
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        advance_i     = adv;
        npc_i         = npc;
        imem_rdata_i  = in_flight ? mem_word(exp_pc) : $urandom();
        if (idle_pending) begin
            idle_pending = 1'b0;
            exp_req      = 1'b1;
        end else if (exp_valid && adv) begin
            exp_cnt   = exp_cnt + 32'd1;
            exp_pc    = npc;
            exp_valid = 1'b0;
            exp_inst  = NOP_INST;
            if (npc[1:0] != 2'b00) exp_mis = 1'b1;
            else exp_req = 1'b1;
        end else if (exp_req && gnt) begin
            exp_req   = 1'b0;
            in_flight = 1'b1;
        end else if (in_flight && rv) begin
            in_flight = 1'b0;
            exp_valid = 1'b1;
            exp_inst  = mem_word(exp_pc);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic        g, v, a;
        rstn = 1'b0; npc_i = 32'd0; advance_i = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
        @(negedge clk);
        do_reset();

        // First fetch after reset with zero-wait grant and 1-cycle rvalid.
        drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
        check_eq("tp1_req",  {31'd0, imem_req_o}, 32'd1);
        check_eq("tp1_addr", imem_addr_o, 32'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
        check_eq("tp1_valid", {31'd0, inst_valid_o}, 32'd1);
        check_eq("tp1_inst",  inst_o, 32'h0050_0093);
        check_eq("tp1_pc",    pc_o, 32'd0);

        // Sequential advance.
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0004);
        check_eq("tp2_pc",    pc_o, 32'h0000_0004);
        check_eq("tp2_valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("tp2_cnt",   fetch_cnt_o, 32'd1);
        check_eq("tp2_req",   {31'd0, imem_req_o}, 32'd1);
        check_eq("tp2_addr",  imem_addr_o, 32'h0000_0004);

        // Grant withheld for 4 cycles, spurious rvalid during REQ.
        for (int i = 0; i < 4; i++) begin
            check_eq("tp3_req",  {31'd0, imem_req_o}, 32'd1);
            check_eq("tp3_addr", imem_addr_o, 32'h0000_0004);
            drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
        end
        check_eq("tp3_valid", {31'd0, inst_valid_o}, 32'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);

        // Advance during WAIT is ignored.
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0800);
        check_eq("tp4_pc",  pc_o, 32'h0000_0004);
        check_eq("tp4_cnt", fetch_cnt_o, 32'd1);
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0800);
        drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
        check_eq("tp4_valid", {31'd0, inst_valid_o}, 32'd1);
        check_eq("tp4_inst",  inst_o, mem_word(32'h0000_0004));

        // Misaligned branch target traps until reset.
        drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_0102);
        check_eq("tp5_mis", {31'd0, misalign_o}, 32'd1);
        check_eq("tp5_pc",  pc_o, 32'h0000_0102);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200);
            check_eq("tp5_req", {31'd0, imem_req_o}, 32'd0);
        end

        // Reset while waiting for data; the stale rvalid lands in IDLE.
        do_reset();
        drive_cycle(1'b0, 1'b0, 1'b0, 32'd0);
        drive_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        do_reset();
        drive_cycle(1'b0, 1'b1, 1'b0, 32'd0);
        check_eq("tp6_valid", {31'd0, inst_valid_o}, 32'd0);
        check_eq("tp6_req",   {31'd0, imem_req_o}, 32'd1);
        check_eq("tp6_addr",  imem_addr_o, RESET_PC);

        // Random memory timing, retire and branch traffic.
        for (int i = 0; i < 4000; i++) begin
            if (exp_mis ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0))
                do_reset();
            r = $urandom();
            g = ($urandom_range(0, 2) != 0);
            v = in_flight ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            a = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) != 0) r = {r[31:2], 2'b00};
            drive_cycle(g, v, a, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
